// File: rtl/tt_um_seq_div.sv
// Tiny Tapeout 4-bit sequential restoring divider with a start/busy/done handshake.
// Optional two's-complement mode is enabled by defining SEQ_DIV_SIGNED_EN.
module tt_um_seq_div #(
  parameter int WIDTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int            CW        = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_FIXUP, S_DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_div;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_r;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;
  logic             r_div0;
`ifdef SEQ_DIV_SIGNED_EN
  logic             r_neg_q;
  logic             r_neg_r;
`endif

  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic             w_start;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_trial;
  logic             w_fits;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [WIDTH-1:0] w_quo_nxt;
  logic             w_unused;

  assign w_a     = WIDTH'(ui_in[3:0]);
  assign w_b     = WIDTH'(ui_in[7:4]);
  assign w_start = uio_in[0];

`ifdef SEQ_DIV_SIGNED_EN
  assign w_a_neg = uio_in[1] & w_a[WIDTH-1];
  assign w_b_neg = uio_in[1] & w_b[WIDTH-1];
`else
  assign w_a_neg = 1'b0;
  assign w_b_neg = 1'b0;
`endif

  // The core always divides magnitudes; the most negative value still fits unsigned.
  assign w_a_mag = w_a_neg ? -w_a : w_a;
  assign w_b_mag = w_b_neg ? -w_b : w_b;

  // One restoring step: the borrow out of the (WIDTH+1)-bit subtract decides the quotient bit.
  assign w_shift   = {r_rem, r_quo[WIDTH-1]};
  assign w_trial   = w_shift - {1'b0, r_div};
  assign w_fits    = ~w_trial[WIDTH];
  assign w_rem_nxt = w_fits ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
  assign w_quo_nxt = {r_quo[WIDTH-2:0], w_fits};

  always_ff @(posedge clk) begin
    // NOTE: every register uses non-blocking (<=) so all updates see pre-edge values.
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_rem   <= '0;
      r_quo   <= '0;
      r_div   <= '0;
      r_q     <= '0;
      r_r     <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_div0  <= 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
`endif
    end else if (ena) begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_start) begin
            if (w_b == '0) begin
              r_q     <= '1;
              r_r     <= w_a;
              r_div0  <= 1'b1;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_rem   <= '0;
              r_quo   <= w_a_mag;
              r_div   <= w_b_mag;
              r_cnt   <= '0;
              r_busy  <= 1'b1;
              r_done  <= 1'b0;
              r_div0  <= 1'b0;
              r_state <= S_BUSY;
`ifdef SEQ_DIV_SIGNED_EN
              r_neg_q <= w_a_neg ^ w_b_neg;
              r_neg_r <= w_a_neg;
`endif
            end
          end
        end

        S_BUSY: begin
          r_rem <= w_rem_nxt;
          r_quo <= w_quo_nxt;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST_STEP) begin
`ifdef SEQ_DIV_SIGNED_EN
            r_state <= S_FIXUP;
`else
            r_q     <= w_quo_nxt;
            r_r     <= w_rem_nxt;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
`endif
          end
        end

`ifdef SEQ_DIV_SIGNED_EN
        S_FIXUP: begin
          r_q     <= r_neg_q ? -r_quo : r_quo;
          r_r     <= r_neg_r ? -r_rem : r_rem;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= S_DONE;
        end
`endif

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign uo_out   = {4'(r_r), 4'(r_q)};
  assign uio_out  = {4'b0000, r_div0, r_done, r_busy, 1'b0};
  assign uio_oe   = 8'b0000_1110;
  assign w_unused = &{1'b0, uio_in[7:1]};

endmodule

// File: tb/tb_tt_um_seq_div.sv
// Scoreboard bench for tt_um_seq_div: arithmetic reference model, random and swept operands,
// start-in-DONE, start-while-BUSY, ena stalls and mid-operation reset.
module tb_tt_um_seq_div;

  localparam int W = 4;
`ifdef SEQ_DIV_SIGNED_EN
  localparam int LAT = W + 1;
`else
  localparam int LAT = W;
`endif

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b0;
  logic       ena    = 1'b1;
  logic [7:0] ui_in  = 8'h00;
  logic [7:0] uio_in = 8'h00;
  wire  [7:0] uo_out;
  wire  [7:0] uio_out;
  wire  [7:0] uio_oe;

  tt_um_seq_div #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uio_in (uio_in),
    .uo_out (uo_out),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] uo;
    logic [7:0] uio;
    int         lat;
    int         cap;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  logic acc_start = 1'b0;
  logic rst_q     = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain integer division; SV / and % truncate toward zero like the signed mode.
  function automatic exp_t model(input logic [3:0] a, input logic [3:0] b, input bit sgn);
    exp_t e;
    int   ia, ib, q, r;
    if (b == 4'd0) begin
      q = 15;
      r = int'(a);
    end else if (sgn) begin
      ia = a[3] ? int'(a) - 16 : int'(a);
      ib = b[3] ? int'(b) - 16 : int'(b);
      q  = ia / ib;
      r  = ia % ib;
    end else begin
      q = int'(a) / int'(b);
      r = int'(a) % int'(b);
    end
    e.uo  = {r[3:0], q[3:0]};
    e.uio = {4'b0000, (b == 4'd0), 1'b1, 2'b00};
    e.lat = (b == 4'd0) ? 0 : LAT;
    e.cap = 0;
    return e;
  endfunction

  always @(posedge clk) begin
    cyc       <= cyc + 1;
    acc_start <= rst_n & ena & uio_in[0];
    rst_q     <= rst_n;
  end

  // Monitor: a result is presented when done rises, or stays high across an accepted start.
  exp_t mon_e;
  int   busy_cnt  = 0;
  bit   prev_done = 1'b0;

  always @(negedge clk) begin
    if (!rst_q) begin
      busy_cnt  = 0;
      prev_done = 1'b0;
    end else begin
      if (uio_out[1]) busy_cnt++;
      if (uio_out[2] && (!prev_done || acc_start)) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: result uo_out=0x%0h appeared with no pending op", uo_out);
        end else begin
          mon_e = sb_q.pop_front();
          check("uo_out", uo_out, mon_e.uo);
          check("uio_out", uio_out, mon_e.uio);
          check("latency", cyc - mon_e.cap, mon_e.lat);
          check("busy_cycles", busy_cnt, mon_e.lat);
          check("uio_oe", uio_oe, 8'h0E);
        end
        busy_cnt = 0;
      end
      prev_done = uio_out[2];
    end
  end

  task automatic do_op(input logic [7:0] x, input bit sgn, input int stall, input bit poke);
    exp_t e;
    int   n;
    int   st;
    st    = poke ? 0 : stall;
    e     = model(x[3:0], x[7:4], sgn);
    if (x[7:4] != 4'd0) e.lat += st;
    ui_in  = x;
    uio_in = {6'b000000, sgn, 1'b1};
    @(posedge clk); #1;
    e.cap = cyc;
    sb_q.push_back(e);
    uio_in = 8'h00;
    @(negedge clk);
    if (x[7:4] != 4'd0) begin
      check("busy_after_start", uio_out[2:1], 2'b01);
      if (poke) begin
        @(posedge clk); #1;
        ui_in  = 8'($urandom);
        uio_in = 8'h01;
        @(posedge clk); #1;
        uio_in = 8'h00;
      end else if (st > 0) begin
        @(posedge clk); #1;
        ena = 1'b0;
        repeat (st) begin
          @(posedge clk); #1;
        end
        ena = 1'b1;
      end
    end
    n = 0;
    while (sb_q.size() != 0 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: op ui_in=0x%0h produced no result within 40 cycles", x);
      sb_q.delete();
    end
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] x;
    bit         sgn;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_uo_out", uo_out, 8'h00);
    check("reset_uio_out", uio_out, 8'h00);
    check("reset_uio_oe", uio_oe, 8'h0E);
    @(posedge clk); #1;
    rst_n = 1'b1;

    do_op(8'h3D, 1'b0, 0, 1'b0);
    do_op(8'h1F, 1'b0, 0, 1'b0);
    do_op(8'h75, 1'b0, 0, 1'b0);
    do_op(8'h09, 1'b0, 0, 1'b0);
    do_op(8'h09, 1'b0, 0, 1'b0);
    do_op(8'h3D, 1'b0, 0, 1'b0);

    // Abort: reset lands two edges after the capture edge.
    ui_in  = 8'h3D;
    uio_in = 8'h01;
    @(posedge clk); #1;
    uio_in = 8'h00;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_uo_out", uo_out, 8'h00);
    check("abort_uio_out", uio_out, 8'h00);
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("idle_after_abort", uio_out, 8'h00);
    @(posedge clk); #1;

    do_op(8'h3D, 1'b0, 3, 1'b0);
    do_op(8'h3D, 1'b0, 0, 1'b1);
    do_op(8'hE7, 1'b0, 0, 1'b0);

`ifdef SEQ_DIV_SIGNED_EN
    do_op(8'h29, 1'b1, 0, 1'b0);
    do_op(8'hF8, 1'b1, 0, 1'b0);
    do_op(8'h09, 1'b1, 0, 1'b0);
    do_op(8'hE7, 1'b1, 0, 1'b0);
`endif

    for (int i = 0; i < 256; i++) do_op(8'(i), 1'b0, 0, 1'b0);

    repeat (80) begin
      x = 8'($urandom);
`ifdef SEQ_DIV_SIGNED_EN
      sgn = 1'($urandom_range(0, 1));
`else
      sgn = 1'b0;
`endif
      do_op(x, sgn, int'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0));
    end

    repeat (5) @(posedge clk);
    check("scoreboard_empty", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tt_um_seq_div.md
Name: tt_um_seq_div

Overview:
- 4-bit sequential restoring divider. It is the inverse companion to the team's combinational carry-lookahead adder.
- Takes dividend A and divisor B on the same packed ui_in layout as the adder. Produces quotient and remainder over WIDTH cycles with a start/busy/done handshake.
- Sits as a Tiny Tapeout user macro; all I/O goes through the standard tt_um pin set.

Parameters:
- WIDTH, 4, operand width in bits. ui_in/uo_out packing is defined for WIDTH=4 only; other values are for internal reuse.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous active-low reset.
- ena  input  1  design enable; when low, all state holds.
- ui_in  input  8  [3:0] = dividend A, [7:4] = divisor B (unsigned by default).
- uio_in  input  8  [0] = start; [1] = signed-mode select (used only with SEQ_DIV_SIGNED_EN); [7:2] ignored.
- uo_out  output  8  [3:0] = quotient Q, [7:4] = remainder R.
- uio_out  output  8  [0] = 0; [1] = busy; [2] = done; [3] = div0; [7:4] = 0.
- uio_oe  output  8  constant 8'b0000_1110.

Behaviour:
- Reset: on a clk edge with rst_n=0:
  - state returns to IDLE;
  - Q, R, busy, done and div0 are all 0, so uo_out=0x00 and uio_out=0x00;
  - reset applies even mid-operation and aborts the division; no partial result is exposed.
- ena=0: state, counter, operand and result registers all hold. Outputs keep their current values.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - start=1 captures A and B.
  - If B!=0: go to BUSY. Internal registers load as rem=0, quo=A, cnt=0. busy=1 next cycle.
  - If B==0: go directly to DONE with Q = all ones, R = A, div0=1, done=1 (single-cycle latency).
- BUSY, one restoring step per cycle:
  - trial = {rem, quo[MSB]} - B, computed at WIDTH+1 bits.
  - If trial is non-negative: rem = trial, shift 1 into quo.
  - Otherwise: rem = {rem, quo[MSB]} truncated to WIDTH, shift 0 into quo.
  - cnt increments each step. On the step where cnt==WIDTH-1, go to DONE.
- Latency: done rises exactly WIDTH cycles after the capture edge (4 cycles at default). busy is high for exactly WIDTH cycles.
- DONE:
  - uo_out holds {R, Q}; done=1, busy=0; div0 holds its value.
  - start=1 in DONE behaves as start in IDLE: captures new operands and clears done and div0 on the same edge. Back-to-back operations therefore need no idle cycle.
  - start=0 keeps the state in DONE indefinitely.
- start while BUSY: ignored; operands are not recaptured.
- uo_out updates only on entry to DONE. During BUSY it shows the previous result, or 0x00 after reset.
- Result invariant when div0=0: A == Q*B + R and R < B.

Optional Feature:
- Macro: SEQ_DIV_SIGNED_EN.
- Defined:
  - uio_in[1] is sampled with start. When 1, A and B are two's complement.
  - Division runs on magnitudes, then one extra FIXUP state (BUSY → FIXUP → DONE) negates Q if the signs differ and negates R if A<0. Latency becomes WIDTH+1.
  - Quotient truncates toward zero; the remainder sign follows the dividend.
  - Signed B==0 gives Q=all ones, R=A, div0=1.
  - -8/-1 overflows: Q=0x8 (wraps), R=0, div0=0.
- Undefined: uio_in[1] is ignored, there is no FIXUP state, and the block is unsigned only.

Test Plan:
- Reset, then ui_in=0x3D (A=13, B=3) with start pulse → busy high for 4 cycles; done at capture+4; uo_out=0x14 (Q=4, R=1).
- ui_in=0x1F (15/1) → uo_out=0x0F. Then start in DONE with ui_in=0x75 (5/7) → done drops on the same edge; 4 cycles later uo_out=0x50.
- ui_in=0x09 (9/0) → one cycle after capture: done=1, div0=1, uo_out=0x9F. Next op 0x3D clears div0.
- Start 0x3D, pull rst_n low at capture+2 → next edge: uio_out=0x00, uo_out=0x00, state IDLE. ena=0 for 3 cycles mid-BUSY → done is delayed by exactly 3 cycles and the result is unchanged.
- Exhaustive sweep, unsigned: all 256 ui_in values → Q*B+R==A and R<B for B!=0; Q=0xF, R=A, div0=1 for B=0.
- SEQ_DIV_SIGNED_EN, uio_in[1]=1, ui_in=0x29 (-7/2) → done at capture+5, uo_out=0xFD (Q=-3, R=-1).
